lif_spike_monitor: RTL and testbench



---
 rtl/lif_mon_pkg.sv | 18 +
 rtl/lif_mon_fifo.sv | 75 +++++++
 rtl/lif_spike_monitor.sv | 151 +++++++++++++++
 tb/tb_lif_spike_monitor.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/lif_mon_pkg.sv
// Shared constants, FSM state type and saturating helper for the LIF spike monitor.
package lif_mon_pkg;

  localparam int LIF_CNT_W    = 8;
  localparam int LIF_DEPTH    = 4;
  localparam int LIF_WIN_LOG2 = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } mon_state_e;

  // Increment that sticks at max_v; callers truncate the result to their width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/lif_mon_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO without a
// concurrent pop is dropped and reported on drop_o for one cycle.
module lif_mon_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o,
  output logic         drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  head_q, head_d;
  logic          empty, full, pop_ok, push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop_i && !empty;
  assign push_ok = push_i && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    // The head register is refilled from the next slot, or bypassed from the
    // incoming word when that word becomes the only entry.
    if (pop_ok) begin
      if (count_q > (AW+1)'(1)) head_d = mem_q[rd_ptr_q + AW'(1)];
      else if (push_ok)         head_d = push_data_i;
    end else if (empty && push_ok) begin
      head_d = push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign head_o  = head_q;
  assign empty_o = empty;
  assign drop_o  = push_i && full && !pop_ok;

endmodule

// File: rtl/lif_spike_monitor.sv
// Spike monitor: edge detect, inter-spike interval measurement into a FIFO and a
// windowed spike rate. Define LIF_SPIKE_MONITOR_MINMAX_EN to add isi_min/isi_max.
module lif_spike_monitor
  import lif_mon_pkg::*;
#(
  parameter int CNT_W    = LIF_CNT_W,
  parameter int DEPTH    = LIF_DEPTH,
  parameter int WIN_LOG2 = LIF_WIN_LOG2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spk,
  input  logic             en,
  output logic [CNT_W-1:0] isi_data,
  output logic             isi_valid,
  input  logic             isi_ready,
  output logic [7:0]       rate,
  output logic             rate_stb,
  output logic             overflow
`ifdef LIF_SPIKE_MONITOR_MINMAX_EN
  ,
  output logic [CNT_W-1:0] isi_min,
  output logic [CNT_W-1:0] isi_max
`endif
);

  localparam logic [CNT_W-1:0]    CNT_MAX = '1;
  localparam logic [WIN_LOG2-1:0] WIN_MAX = '1;

  logic                spk_q;
  mon_state_e          state_q, state_d;
  logic [CNT_W-1:0]    isi_cnt_q, isi_cnt_d;
  logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic [7:0]          spk_count_q, spk_count_d, spk_inc;
  logic [7:0]          rate_q, rate_d;
  logic                rate_stb_q, rate_stb_d;
  logic                overflow_q;
  logic                spk_ev, isi_push, fifo_empty, fifo_drop;

  assign spk_ev = en && spk && !spk_q;

  always_comb begin
    state_d   = state_q;
    isi_cnt_d = isi_cnt_q;
    isi_push  = 1'b0;
    if (!en) begin
      state_d   = IDLE;
      isi_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (spk_ev) begin
            state_d   = ARMED;
            isi_cnt_d = CNT_W'(1);
          end
        end
        ARMED: begin
          if (spk_ev) begin
            isi_push  = 1'b1;
            isi_cnt_d = CNT_W'(1);
          end else begin
            isi_cnt_d = CNT_W'(sat_inc(32'(isi_cnt_q), 32'(CNT_MAX)));
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A spike landing in the wrap cycle still belongs to the window being closed.
  always_comb begin
    win_cnt_d   = win_cnt_q;
    spk_count_d = spk_count_q;
    rate_d      = rate_q;
    rate_stb_d  = 1'b0;
    spk_inc     = spk_ev ? 8'(sat_inc(32'(spk_count_q), 32'd255)) : spk_count_q;
    if (!en) begin
      win_cnt_d   = '0;
      spk_count_d = '0;
    end else begin
      win_cnt_d = win_cnt_q + WIN_LOG2'(1);
      if (win_cnt_q == WIN_MAX) begin
        rate_d      = spk_inc;
        rate_stb_d  = 1'b1;
        spk_count_d = '0;
      end else begin
        spk_count_d = spk_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spk_q       <= 1'b0;
      state_q     <= IDLE;
      isi_cnt_q   <= '0;
      win_cnt_q   <= '0;
      spk_count_q <= '0;
      rate_q      <= '0;
      rate_stb_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      spk_q       <= spk;
      state_q     <= state_d;
      isi_cnt_q   <= isi_cnt_d;
      win_cnt_q   <= win_cnt_d;
      spk_count_q <= spk_count_d;
      rate_q      <= rate_d;
      rate_stb_q  <= rate_stb_d;
      if (fifo_drop) overflow_q <= 1'b1;
    end
  end

  lif_mon_fifo #(
    .W     (CNT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (isi_push),
    .push_data_i (isi_cnt_q),
    .pop_i       (isi_ready),
    .head_o      (isi_data),
    .empty_o     (fifo_empty),
    .drop_o      (fifo_drop)
  );

  assign isi_valid = !fifo_empty;
  assign rate      = rate_q;
  assign rate_stb  = rate_stb_q;
  assign overflow  = overflow_q;

`ifdef LIF_SPIKE_MONITOR_MINMAX_EN
  logic [CNT_W-1:0] isi_min_q, isi_max_q;

  // Tracks every measured interval, including ones the FIFO had to drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      isi_min_q <= '1;
      isi_max_q <= '0;
    end else if (isi_push) begin
      if (isi_cnt_q < isi_min_q) isi_min_q <= isi_cnt_q;
      if (isi_cnt_q > isi_max_q) isi_max_q <= isi_cnt_q;
    end
  end

  assign isi_min = isi_min_q;
  assign isi_max = isi_max_q;
`endif

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Randomised and directed stimulus against a cycle-time reference model with a
// scoreboard queue of expected ISIs and an independent output monitor.
module tb_lif_spike_monitor;

  localparam int CNT_W    = 8;
  localparam int DEPTH    = 4;
  localparam int WIN_LOG2 = 4;
  localparam int WIN_LEN  = 1 << WIN_LOG2;
  localparam int ISI_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset, spk, en, isi_ready;
  logic [CNT_W-1:0] isi_data;
  logic             isi_valid;
  logic [7:0]       rate;
  logic             rate_stb, overflow;
`ifdef LIF_SPIKE_MONITOR_MINMAX_EN
  logic [CNT_W-1:0] isi_min, isi_max;
`endif

  lif_spike_monitor #(
    .CNT_W    (CNT_W),
    .DEPTH    (DEPTH),
    .WIN_LOG2 (WIN_LOG2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .spk       (spk),
    .en        (en),
    .isi_data  (isi_data),
    .isi_valid (isi_valid),
    .isi_ready (isi_ready),
    .rate      (rate),
    .rate_stb  (rate_stb),
    .overflow  (overflow)
`ifdef LIF_SPIKE_MONITOR_MINMAX_EN
    ,
    .isi_min   (isi_min),
    .isi_max   (isi_max)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: absolute cycle times of spike events.
  int cyc = 0;
  int t_ref = -1;
  bit prev_spk = 1'b0;
  bit ev_m;
  int isi_m;
  int exp_q[$];
  bit exp_ovf = 1'b0;
  int win_n = 0;
  int win_spk = 0;
  int exp_rate = 0;
  bit exp_stb = 1'b0;
  int exp_min = ISI_MAX;
  int exp_max = 0;
  int exp_head;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      prev_spk = 1'b0;
      t_ref    = -1;
      exp_q.delete();
      exp_ovf  = 1'b0;
      win_n    = 0;
      win_spk  = 0;
      exp_rate = 0;
      exp_stb  = 1'b0;
      exp_min  = ISI_MAX;
      exp_max  = 0;
    end else begin
      ev_m     = en && spk && !prev_spk;
      prev_spk = spk;
      exp_stb  = 1'b0;
      if (!en) begin
        t_ref   = -1;
        win_n   = 0;
        win_spk = 0;
      end else begin
        if (ev_m) begin
          if (t_ref >= 0) begin
            isi_m = cyc - t_ref;
            if (isi_m > ISI_MAX) isi_m = ISI_MAX;
            if (isi_m < exp_min) exp_min = isi_m;
            if (isi_m > exp_max) exp_max = isi_m;
            // Occupancy already reflects a pop the monitor saw accepted at this edge.
            if (exp_q.size() < DEPTH) exp_q.push_back(isi_m);
            else exp_ovf = 1'b1;
          end
          t_ref = cyc;
          win_spk++;
        end
        win_n++;
        if (win_n == WIN_LEN) begin
          exp_rate = (win_spk > 255) ? 255 : win_spk;
          exp_stb  = 1'b1;
          win_n    = 0;
          win_spk  = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("isi_valid", int'(isi_valid), int'(exp_q.size() != 0));
    chk("overflow", int'(overflow), int'(exp_ovf));
    chk("rate_stb", int'(rate_stb), int'(exp_stb));
    chk("rate", int'(rate), exp_rate);
`ifdef LIF_SPIKE_MONITOR_MINMAX_EN
    chk("isi_min", int'(isi_min), exp_min);
    chk("isi_max", int'(isi_max), exp_max);
`endif
    if (rate_stb) $display("[TB] cycle %0d rate update: rate=%0d expected=%0d", cyc, rate, exp_rate);
    if (isi_valid && isi_ready && !reset && exp_q.size() != 0) begin
      exp_head = exp_q.pop_front();
      chk("isi_data", int'(isi_data), exp_head);
      $display("[TB] cycle %0d isi pop: data=%0d expected=%0d", cyc, isi_data, exp_head);
    end
  end

  task automatic drv(input bit s, input bit e, input bit r);
    spk = s;
    en = e;
    isi_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int gap, input bit r);
    drv(1'b1, 1'b1, r);
    repeat (gap - 1) drv(1'b0, 1'b1, r);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drv(1'b1, 1'b1, 1'b0);
    drv(1'b1, 1'b1, 1'b0);
    reset = 1'b0;
  endtask

  task automatic drain();
    repeat (DEPTH + 2) drv(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    spk = 1'b1;
    en = 1'b1;
    isi_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // First rise after reset only arms the interval counter.
    repeat (3) drv(1'b1, 1'b1, 1'b0);
    repeat (4) drv(1'b0, 1'b1, 1'b0);
    do_reset();

    // Rises 7 and 13 cycles apart, consumer stalled.
    repeat (9) drv(1'b0, 1'b1, 1'b0);
    pulse(7, 1'b0);
    pulse(13, 1'b0);
    drv(1'b1, 1'b1, 1'b0);
    drv(1'b0, 1'b1, 1'b0);
    repeat (3) drv(1'b0, 1'b0, 1'b0);
    drain();

    // Held-high level followed by a 300-cycle gap saturates to all-ones.
    repeat (5) drv(1'b1, 1'b1, 1'b0);
    repeat (295) drv(1'b0, 1'b1, 1'b0);
    drv(1'b1, 1'b1, 1'b0);
    drv(1'b0, 1'b1, 1'b0);
    drv(1'b0, 1'b0, 1'b0);
    drain();

    // Fill the FIFO, then a spike coincides with a pop: no drop.
    repeat (5) pulse(5, 1'b0);
    drv(1'b1, 1'b1, 1'b1);
    drv(1'b0, 1'b1, 1'b0);
    drv(1'b0, 1'b0, 1'b0);
    drain();

    // Six intervals into a stalled FIFO: two dropped, overflow sticks.
    repeat (6) pulse(4, 1'b0);
    drv(1'b1, 1'b1, 1'b0);
    drv(1'b0, 1'b0, 1'b0);
    repeat (4) drv(1'b0, 1'b0, 1'b1);
    repeat (3) drv(1'b0, 1'b0, 1'b0);

    // Periodic spikes for the rate window, with en dropped mid-window.
    do_reset();
    repeat (20) pulse(3, 1'b1);
    repeat (7) drv(1'b0, 1'b0, 1'b1);
    repeat (20) pulse(3, 1'b1);
    drv(1'b0, 1'b0, 1'b1);

    // Random traffic with varying consumer throughput.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 700; i++) begin
        drv($urandom_range(0, 2) == 0,
            $urandom_range(0, 63) != 0,
            $urandom_range(0, 3) < ph);
      end
    end

    drain();
    chk("final_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
